id_ex_reg: RTL

- ID/EX pipeline stage directly upstream of the ULA.
- Latches the decoded operands, immediate, shift amount and 4-bit ULA opcode from decode.
- Applies EX/MEM and MEM/WB forwarding and operand-source selection, then drives the ULA In1, In2 and OP inputs.
- Owns the valid/ready handshake, flush and the load-use stall (one bubble).

---
 rtl/ula_pkg.sv | 43 ++++
 rtl/fwd_mux.sv | 28 ++
 rtl/id_ex_reg.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared widths, ULA opcodes, operand-select encodings and the ID/EX payload.
package ula_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RA_W    = 5;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_NOR  = 4'd5;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd6;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd7;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd8;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd9;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd10;
    localparam logic [OP_W-1:0] OP_LUI  = 4'd11;

    localparam logic A_SEL_RS    = 1'b0;
    localparam logic A_SEL_SHAMT = 1'b1;
    localparam logic B_SEL_RT    = 1'b0;
    localparam logic B_SEL_IMM   = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0]    rs_data;
        logic [XLEN-1:0]    rt_data;
        logic [XLEN-1:0]    imm;
        logic [SHAMT_W-1:0] shamt;
        logic [OP_W-1:0]    op;
        logic               a_sel;
        logic               b_sel;
        logic [RA_W-1:0]    rs;
        logic [RA_W-1:0]    rt;
        logic [RA_W-1:0]    rd;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
    } id_ex_entry_t;

endpackage

// File: rtl/fwd_mux.sv
// One operand's forwarding select: EX/MEM beats MEM/WB, register 0 never forwarded.
module fwd_mux
    import ula_pkg::*;
(
    input  logic [RA_W-1:0] src,
    input  logic [XLEN-1:0] reg_val,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] operand_c
);

    logic src_nz;
    assign src_nz = (src != '0);

    always_comb begin
        operand_c = reg_val;
        if (exmem_reg_write && (exmem_rd == src) && src_nz) begin
            operand_c = exmem_result;
        end else if (memwb_reg_write && (memwb_rd == src) && src_nz) begin
            operand_c = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register feeding the ULA: handshake, flush, load-use bubble, forwarding.
// Optional perf counters enabled by defining ID_EX_PERF_EN.
module id_ex_reg
    import ula_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    id_rs_data,
    input  logic [XLEN-1:0]    id_rt_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [SHAMT_W-1:0] id_shamt,
    input  logic [OP_W-1:0]    id_op,
    input  logic               id_a_sel,
    input  logic               id_b_sel,
    input  logic [RA_W-1:0]    id_rs,
    input  logic [RA_W-1:0]    id_rt,
    input  logic [RA_W-1:0]    id_rd,
    input  logic               id_uses_rt,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               flush,
    input  logic               exmem_reg_write,
    input  logic [RA_W-1:0]    exmem_rd,
    input  logic [XLEN-1:0]    exmem_result,
    input  logic               memwb_reg_write,
    input  logic [RA_W-1:0]    memwb_rd,
    input  logic [XLEN-1:0]    memwb_result,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_in1,
    output logic [XLEN-1:0]    ex_in2,
    output logic [OP_W-1:0]    ex_op,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [RA_W-1:0]    ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               load_use_stall
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt,
    output logic [31:0]        perf_bubble_cnt
`endif
);

    logic         valid_q;
    id_ex_entry_t entry_q;
    id_ex_entry_t entry_d;
    logic         hazard_c;
    logic         capture_c;
    logic [XLEN-1:0] fwd_rs_c;
    logic [XLEN-1:0] fwd_rt_c;

    // Stalled consumer waits one cycle while the load leaves; the re-check then sees a bubble.
    assign hazard_c = valid_q && entry_q.mem_read && entry_q.reg_write && (entry_q.rd != '0)
                      && in_valid
                      && ((id_rs == entry_q.rd) || (id_uses_rt && (id_rt == entry_q.rd)));

    assign in_ready  = (!valid_q || ex_ready) && !hazard_c;
    assign capture_c = in_valid && in_ready && !flush && !hazard_c;

    always_comb begin
        entry_d           = '0;
        entry_d.rs_data   = id_rs_data;
        entry_d.rt_data   = id_rt_data;
        entry_d.imm       = id_imm;
        entry_d.shamt     = id_shamt;
        entry_d.op        = id_op;
        entry_d.a_sel     = id_a_sel;
        entry_d.b_sel     = id_b_sel;
        entry_d.rs        = id_rs;
        entry_d.rt        = id_rt;
        entry_d.rd        = id_rd;
        entry_d.reg_write = id_reg_write;
        entry_d.mem_read  = id_mem_read;
        entry_d.mem_write = id_mem_write;
    end

    // Flush > capture > drain; payload only changes on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture_c) begin
            valid_q <= 1'b1;
            entry_q <= entry_d;
        end else if (valid_q && ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    fwd_mux u_fwd_rs (
        .src             (entry_q.rs),
        .reg_val         (entry_q.rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .operand_c       (fwd_rs_c)
    );

    fwd_mux u_fwd_rt (
        .src             (entry_q.rt),
        .reg_val         (entry_q.rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .operand_c       (fwd_rt_c)
    );

    assign ex_valid       = valid_q;
    assign ex_in1         = (entry_q.a_sel == A_SEL_SHAMT) ? XLEN'(entry_q.shamt) : fwd_rs_c;
    assign ex_in2         = (entry_q.b_sel == B_SEL_IMM) ? entry_q.imm : fwd_rt_c;
    assign ex_store_data  = fwd_rt_c;
    assign ex_op          = entry_q.op;
    assign ex_rd          = entry_q.rd;
    assign ex_reg_write   = valid_q && entry_q.reg_write;
    assign ex_mem_read    = valid_q && entry_q.mem_read;
    assign ex_mem_write   = valid_q && entry_q.mem_write;
    assign load_use_stall = hazard_c;

`ifdef ID_EX_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt  <= '0;
            perf_flush_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (hazard_c && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (flush && valid_q && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
            if (!valid_q && ex_ready && (perf_bubble_cnt != '1)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
